// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from asynchronous VGA hsync/vsync and locks to the
// incoming timing after a run of consistent frames.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] col_count,
  output logic [9:0] row_count,
  output logic       valid,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);

  localparam int unsigned HTO_W = $clog2(2 * H_TOTAL);
  localparam int unsigned VTO_W = $clog2(2 * V_TOTAL);
  localparam int unsigned GC_W  = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_SYNC   = 10'(H_SYNC_START);
  localparam logic [9:0]       V_SYNC   = 10'(V_SYNC_START);
  localparam logic [9:0]       H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
  localparam logic [HTO_W-1:0] HTO_MAX  = HTO_W'(2 * H_TOTAL - 1);
  localparam logic [VTO_W-1:0] VTO_MAX  = VTO_W'(2 * V_TOTAL - 1);
  localparam logic [GC_W-1:0]  GC_LOCK  = GC_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  logic             hs_meta_q, hs_sync_q, hs_prev_q;
  logic             vs_meta_q, vs_sync_q, vs_prev_q;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic [HTO_W-1:0] h_to_q, h_to_d;
  logic [VTO_W-1:0] v_to_q, v_to_d;
  logic [GC_W-1:0]  good_q, good_d;
  state_e           state_q, state_d;
  logic             sync_err_q, sync_err_d;

  logic             hs_fall_s, vs_fall_s;
  logic             h_wrap_s;
  logic [9:0]       h_free_s, v_free_s;
  logic             hs_bad_s, vs_bad_s, timeout_s, err_s;

  // Two-flop synchronizers plus one history flop per sync for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_meta_q <= 1'b1;
      hs_sync_q <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      hs_meta_q <= hsync;
      hs_sync_q <= hs_meta_q;
      hs_prev_q <= hs_sync_q;
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  // Free-running position, realignment on sync edges, edge quality and timeouts
  always_comb begin
    hs_fall_s = hs_prev_q & ~hs_sync_q;
    vs_fall_s = vs_prev_q & ~vs_sync_q;
    h_wrap_s  = (h_cnt_q == H_LAST);
    h_free_s  = 10'd0;
    v_free_s  = v_cnt_q;
    if (h_wrap_s) begin
      h_free_s = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_free_s = 10'd0;
      end else begin
        v_free_s = v_cnt_q + 10'd1;
      end
    end else begin
      h_free_s = h_cnt_q + 10'd1;
    end

    h_cnt_d  = hs_fall_s ? H_SYNC : h_free_s;
    v_cnt_d  = vs_fall_s ? V_SYNC : v_free_s;
    hs_bad_s = hs_fall_s && (h_free_s != H_SYNC);
    vs_bad_s = vs_fall_s && (v_free_s != V_SYNC);

    timeout_s = 1'b0;
    if (!hs_fall_s && (h_to_q == HTO_MAX)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    if (!vs_fall_s && h_wrap_s && (v_to_q == VTO_MAX)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = timeout_s;
    end

    // Timeout counters restart after firing so a dead input keeps re-flagging
    if (hs_fall_s || (h_to_q == HTO_MAX)) begin
      h_to_d = '0;
    end else begin
      h_to_d = h_to_q + HTO_W'(1);
    end
    if (vs_fall_s || (h_wrap_s && (v_to_q == VTO_MAX))) begin
      v_to_d = '0;
    end else if (h_wrap_s) begin
      v_to_d = v_to_q + VTO_W'(1);
    end else begin
      v_to_d = v_to_q;
    end

    err_s = hs_bad_s | vs_bad_s | timeout_s;
  end

  // Acquisition state machine: SEARCH -> CHECK -> LOCKED
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    sync_err_d = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vs_fall_s) begin
          state_d = ST_CHECK;
          good_d  = '0;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_CHECK: begin
        if (err_s) begin
          state_d = ST_SEARCH;
          good_d  = '0;
        end else if (vs_fall_s) begin
          good_d = good_q + GC_W'(1);
          if ((good_q + GC_W'(1)) == GC_LOCK) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_LOCKED: begin
        if (err_s) begin
          state_d    = ST_SEARCH;
          good_d     = '0;
          sync_err_d = 1'b1;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        good_d  = '0;
      end
    endcase
  end

  // Counter, timeout and state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q    <= 10'd0;
      v_cnt_q    <= 10'd0;
      h_to_q     <= '0;
      v_to_q     <= '0;
      good_q     <= '0;
      state_q    <= ST_SEARCH;
      sync_err_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      h_to_q     <= h_to_d;
      v_to_q     <= v_to_d;
      good_q     <= good_d;
      state_q    <= state_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign col_count   = h_cnt_q;
  assign row_count   = v_cnt_q;
  assign locked      = (state_q == ST_LOCKED);
  assign valid       = locked && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign frame_start = locked && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken 24x13 raster
// (16x8 visible, hsync low cols 18-21, vsync low rows 10-11).
module tb_vga_sync_decoder;

  localparam int HV = 16, HS = 18, HT = 24;
  localparam int VV = 8,  VS = 10, VT = 13;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] col_count, row_count;
  logic       valid, locked, frame_start, sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // transmitter model
  int tx_col = 0, tx_row = 0;
  int tx_short_row = -1;
  bit tx_hs_mask = 1'b0;
  int h1c = 0, h1r = 0, h2c = 0, h2r = 0, h3c = 0, h3r = 0;
  int exp_col, exp_row;

  // sampled DUT outputs
  int obs_col, obs_row;
  bit obs_valid, obs_locked, obs_fs, obs_err, prev_locked;
  int bound_viol = 0;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_SYNC_START(HS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VS), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .col_count(col_count), .row_count(row_count), .valid(valid),
    .locked(locked), .frame_start(frame_start), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // One pixel: sample outputs, then drive the next transmitted position.
  task automatic step();
    int last;
    @(posedge clk);
    #1;
    prev_locked = obs_locked;
    obs_col    = int'(col_count);
    obs_row    = int'(row_count);
    obs_valid  = valid;
    obs_locked = locked;
    obs_fs     = frame_start;
    obs_err    = sync_err;
    if (obs_col >= HT || obs_row >= VT) bound_viol++;
    exp_col = h3c; exp_row = h3r;
    h3c = h2c; h3r = h2r; h2c = h1c; h2r = h1r; h1c = tx_col; h1r = tx_row;
    hsync = tx_hs_mask ? 1'b1 : !(tx_col >= HS && tx_col < HS + 4);
    vsync = !(tx_row >= VS && tx_row < VS + 2);
    last = (tx_row == tx_short_row) ? HT - 2 : HT - 1;
    if (tx_col == last) begin
      tx_col = 0;
      tx_row = (tx_row + 1) % VT;
    end else begin
      tx_col++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (col_count !== 10'd0 || row_count !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_counters: col=%0d row=%0d expected 0/0", col_count, row_count);
    end
    n_checks++;
    if ({valid, locked, frame_start, sync_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: v/l/fs/e=%b expected 0000", {valid, locked, frame_start, sync_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    repeat (2) @(posedge clk);
    #1;
    hsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (col_count !== 10'd18) begin
      n_fail++;
      $display("FAIL latency_n3: col=%0d expected 18", col_count);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (col_count !== 10'd19 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n4: col=%0d locked=%b expected 19/0", col_count, locked);
    end
    hsync = 1'b1;
  endtask

  task automatic test_lock();
    int rise = -1, vcnt = 0, fcnt = 0, lcnt = 0, ecnt = 0, pmis = 0;
    for (int c = 0; c < 5 * FRAME; c++) begin
      step();
      if (obs_locked && rise < 0) rise = c;
      if (c >= 3 * FRAME) begin
        vcnt += int'(obs_valid);
        fcnt += int'(obs_fs);
        lcnt += int'(obs_locked);
        ecnt += int'(obs_err);
        if (obs_col != exp_col || obs_row != exp_row) pmis++;
      end
    end
    n_checks++;
    if (rise != 2 * FRAME + VS * HT + 3) begin
      n_fail++;
      $display("FAIL lock_rise: locked rose at %0d expected %0d", rise, 2 * FRAME + VS * HT + 3);
    end
    n_checks++;
    if (vcnt != 2 * HV * VV || fcnt != 2) begin
      n_fail++;
      $display("FAIL lock_valid_fs: valid=%0d fs=%0d expected %0d/2", vcnt, fcnt, 2 * HV * VV);
    end
    n_checks++;
    if (lcnt != 2 * FRAME || ecnt != 0 || pmis != 0) begin
      n_fail++;
      $display("FAIL lock_stable: locked=%0d err=%0d posmis=%0d expected %0d/0/0", lcnt, ecnt, pmis, 2 * FRAME);
    end
  endtask

  task automatic test_vs_wrap();
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (exp_row == VS - 1 && exp_col == HT - 1) begin
        n_checks++;
        if (obs_row != VS - 1 || obs_col != HT - 1) begin
          n_fail++;
          $display("FAIL vswrap_before: col=%0d row=%0d expected %0d/%0d", obs_col, obs_row, HT - 1, VS - 1);
        end
      end
      if (exp_row == VS && exp_col == 0) begin
        n_checks++;
        if (obs_row != VS || obs_col != 0 || obs_err || !obs_locked) begin
          n_fail++;
          $display("FAIL vswrap_load: col=%0d row=%0d err=%b locked=%b expected 0/%0d/0/1", obs_col, obs_row, obs_err, obs_locked, VS);
        end
      end
    end
  endtask

  task automatic test_short_line();
    int ecnt = 0, eidx = -1;
    bit l_at_err = 1'b1, pl_at_err = 1'b0, l860 = 1'b1, l870 = 1'b0;
    tx_short_row = 2;
    for (int c = 0; c < 4 * FRAME - 1; c++) begin
      step();
      if (tx_row == 5) tx_short_row = -1;
      if (obs_err) begin
        ecnt++;
        if (eidx < 0) begin
          eidx = c; l_at_err = obs_locked; pl_at_err = prev_locked;
        end
      end
      if (c == 860) l860 = obs_locked;
      if (c == 870) l870 = obs_locked;
    end
    n_checks++;
    if (ecnt != 1 || eidx != 92) begin
      n_fail++;
      $display("FAIL short_err: pulses=%0d at %0d expected 1 at 92", ecnt, eidx);
    end
    n_checks++;
    if (l_at_err !== 1'b0 || pl_at_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_drop: locked=%b prev=%b expected 0/1", l_at_err, pl_at_err);
    end
    n_checks++;
    if (l860 !== 1'b0 || l870 !== 1'b1) begin
      n_fail++;
      $display("FAIL short_relock: locked@860=%b @870=%b expected 0/1", l860, l870);
    end
    n_checks++;
    if (obs_col != exp_col || obs_row != exp_row) begin
      n_fail++;
      $display("FAIL short_pos: col=%0d row=%0d expected %0d/%0d", obs_col, obs_row, exp_col, exp_row);
    end
  endtask

  task automatic test_hsync_timeout();
    int ecnt = 0, eidx = -1;
    bit v60 = 1'b1, l60 = 1'b1;
    for (int c = 0; c < 4 * FRAME; c++) begin
      tx_hs_mask = (c < 60);
      step();
      if (obs_err) begin
        ecnt++;
        if (eidx < 0) eidx = c;
      end
      if (c == 60) begin
        v60 = obs_valid; l60 = obs_locked;
      end
    end
    tx_hs_mask = 1'b0;
    n_checks++;
    if (ecnt != 1 || eidx != 45) begin
      n_fail++;
      $display("FAIL timeout_err: pulses=%0d at %0d expected 1 at 45", ecnt, eidx);
    end
    n_checks++;
    if (v60 !== 1'b0 || l60 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: valid=%b locked=%b expected 0/0", v60, l60);
    end
    n_checks++;
    if (obs_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_relock: locked=%b expected 1", obs_locked);
    end
  endtask

  task automatic test_async_reset();
    int lcnt = 0;
    bit l900 = 1'b0;
    for (int c = 0; c < 100; c++) step();
    n_checks++;
    if (obs_locked !== 1'b1 || obs_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: locked=%b valid=%b expected 1/1", obs_locked, obs_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (col_count !== 10'd0 || row_count !== 10'd0 ||
        {valid, locked, frame_start, sync_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_now: col=%0d row=%0d v/l/fs/e=%b expected 0/0/0000", col_count, row_count, {valid, locked, frame_start, sync_err});
    end
    for (int c = 100; c < 103; c++) step();
    rst_n = 1'b1;
    for (int c = 103; c < 1000; c++) begin
      step();
      if (c < 866) lcnt += int'(obs_locked);
      if (c == 900) l900 = obs_locked;
    end
    n_checks++;
    if (lcnt != 0 || l900 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_relock: early locked=%0d locked@900=%b expected 0/1", lcnt, l900);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_lock();
    test_vs_wrap();
    test_short_line();
    test_hsync_timeout();
    test_async_reset();
    n_checks++;
    if (bound_viol != 0) begin
      n_fail++;
      $display("FAIL counter_bounds: %0d out-of-range samples expected 0", bound_viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
